trip_latch_controller: RTL

Multi-channel trip latch and alarm-path self-test controller for the protection logic. Latches N_CH raw fault inputs into held trips, drives the OR'd alarm, and sequences a channel-by-channel self-test that injects a test request onto each alarm line and checks the external readback within a bounded window. Operator acknowledge clears only channels whose fault has gone away. Sits between the raw channel comparators and the alarm output drivers.

---
 rtl/trip_latch_controller_pkg.sv | 18 +
 rtl/trip_latch_controller_if.sv | 36 +++
 rtl/trip_latch_controller_chan_latch.sv | 17 +
 rtl/trip_latch_controller.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/trip_latch_controller_pkg.sv
// Shared types for the trip latch controller: self-test FSM states and
// the channel-index width helper used by the interface and the top.
package trip_latch_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INJECT,
    ST_RELEASE,
    ST_NEXT,
    ST_DONE,
    ST_FAIL
  } state_t;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/trip_latch_controller_if.sv
// Channel fault/readback inputs and trip/alarm/self-test outputs of the trip
// latch controller; master drives the fault side, slave is the controller.
interface trip_latch_controller_if #(
  parameter int N_CH = 4
);
  import trip_latch_controller_pkg::*;

  localparam int CHW = ch_w(N_CH);

  logic [N_CH-1:0] fault_in;
  logic [N_CH-1:0] la_fb;
  logic            ack_req;
  logic            test_start;
  logic            test_en;
  logic [N_CH-1:0] trip;
  logic [N_CH-1:0] la_test;
  logic            alarm;
  logic            test_busy;
  logic            test_pass;
  logic            test_fail;
  logic [CHW-1:0]  test_fail_ch;
  logic            ack_done;

  modport master (
    output fault_in, la_fb, ack_req, test_start, test_en,
    input  trip, la_test, alarm, test_busy, test_pass, test_fail,
           test_fail_ch, ack_done
  );

  modport slave (
    input  fault_in, la_fb, ack_req, test_start, test_en,
    output trip, la_test, alarm, test_busy, test_pass, test_fail,
           test_fail_ch, ack_done
  );

endinterface

// File: rtl/trip_latch_controller_chan_latch.sv
// One held trip: a live fault sets it, ack clears it only once the fault is gone.
// One cycle fault-to-trip; no flow control.
module trip_latch_controller_chan_latch (
  input  logic clk,
  input  logic reset,
  input  logic fault,
  input  logic clr,
  output logic trip
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      trip <= 1'b0;
    else if (fault) trip <= 1'b1;
    else if (clr)   trip <= 1'b0;
  end

endmodule

// File: rtl/trip_latch_controller.sv
// Trip latches, OR'd alarm and channel-by-channel alarm-path self-test.
// Trip 1 cycle after fault; alarm combinational from registered state; no backpressure.
module trip_latch_controller
  import trip_latch_controller_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int TEST_PERIOD = 1000,
  parameter int RESP_WIN    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  trip_latch_controller_if.slave  bus
);

  localparam int CHW = ch_w(N_CH);
  localparam int WW  = $clog2(RESP_WIN + 1);
  localparam int PW  = $clog2(TEST_PERIOD);
  localparam logic [N_CH-1:0] ONE_HOT0 = 1;

  state_t          state, state_nxt;
  logic [CHW-1:0]  ch, ch_nxt;
  logic [WW-1:0]   win, win_nxt;
  logic [PW-1:0]   per_cnt;
  logic            pending;
  logic            per_wrap;
  logic            launch;
  logic            fail_set;
  logic            fb_ch;
  logic            win_last;
  logic [N_CH-1:0] trip_q;
  logic [N_CH-1:0] la_test_w;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    trip_latch_controller_chan_latch u_latch (
      .clk   (clk),
      .reset (reset),
      .fault (bus.fault_in[i]),
      .clr   (bus.ack_req),
      .trip  (trip_q[i])
    );
  end

  assign fb_ch    = bus.la_fb[ch];
  assign win_last = (win == WW'(RESP_WIN - 1));
  // Launch looks at the registered trips, so a same-cycle ack cannot open the gate early.
  assign launch   = (state == ST_IDLE) && (bus.test_start || pending) && (trip_q == '0);
  assign per_wrap = bus.test_en && (per_cnt == PW'(TEST_PERIOD - 1));

  always_comb begin
    state_nxt = state;
    ch_nxt    = ch;
    win_nxt   = win;
    fail_set  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (launch) begin
          state_nxt = ST_INJECT;
          ch_nxt    = '0;
          win_nxt   = '0;
        end
      end
      ST_INJECT: begin
        if (fb_ch) begin
          state_nxt = ST_RELEASE;
          win_nxt   = '0;
        end else if (win_last) begin
          state_nxt = ST_FAIL;
          fail_set  = 1'b1;
        end else begin
          win_nxt = win + 1'b1;
        end
      end
      ST_RELEASE: begin
        // A tripped channel legitimately holds its line high, so the release check is skipped.
        if (trip_q[ch] || !fb_ch) begin
          state_nxt = ST_NEXT;
        end else if (win_last) begin
          state_nxt = ST_FAIL;
          fail_set  = 1'b1;
        end else begin
          win_nxt = win + 1'b1;
        end
      end
      ST_NEXT: begin
        if (ch == CHW'(N_CH - 1)) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_INJECT;
          ch_nxt    = ch + 1'b1;
          win_nxt   = '0;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      ST_FAIL: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      ch    <= '0;
      win   <= '0;
    end else begin
      state <= state_nxt;
      ch    <= ch_nxt;
      win   <= win_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      per_cnt <= '0;
      pending <= 1'b0;
    end else if (!bus.test_en) begin
      per_cnt <= '0;
      pending <= 1'b0;
    end else begin
      per_cnt <= per_wrap ? '0 : per_cnt + 1'b1;
      pending <= per_wrap || (pending && !launch);
    end
  end

  // A new failure takes priority over a same-cycle ack so it is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.test_fail    <= 1'b0;
      bus.test_fail_ch <= '0;
      bus.ack_done     <= 1'b0;
    end else begin
      bus.ack_done <= bus.ack_req;
      if (fail_set) begin
        bus.test_fail    <= 1'b1;
        bus.test_fail_ch <= ch;
      end else if (bus.ack_req) begin
        bus.test_fail    <= 1'b0;
        bus.test_fail_ch <= '0;
      end
    end
  end

  assign la_test_w     = (state == ST_INJECT) ? (ONE_HOT0 << ch) : '0;
  assign bus.la_test   = la_test_w;
  assign bus.trip      = trip_q;
  assign bus.alarm     = (|trip_q) || (|la_test_w);
  assign bus.test_busy = (state == ST_INJECT) || (state == ST_RELEASE) || (state == ST_NEXT);
  assign bus.test_pass = (state == ST_DONE);

endmodule
